// File: rtl/fpu_cvt_sched_if.sv
// Request/response channel bundle between the requesters/consumer and the
// shared float-to-int32 conversion scheduler.
interface fpu_cvt_sched_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_result;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_invalid;
  logic               rsp_inexact;

  // Requester/consumer side.
  modport master (
    output req_valid, req_a, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_id, rsp_invalid, rsp_inexact
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_id, rsp_invalid, rsp_inexact
  );
endinterface

// File: rtl/fpu_cvt_sched.sv
// Round-robin scheduler and sequencer for the shared float-to-int32
// converter. One conversion in flight: IDLE -> DECODE -> SHIFT -> RESP.
// Result is truncated toward zero, saturating with invalid/inexact flags.
module fpu_cvt_sched #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  fpu_cvt_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_SHIFT  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [31:0]    opnd_q;
  logic [IDW-1:0] id_q;

  // Work registers loaded in DECODE and consumed in SHIFT.
  logic           norm_q;
  logic           sign_q;
  logic [23:0]    sig_q;
  logic [4:0]     sh_q;
  logic [31:0]    wres_q;
  logic           winv_q;
  logic           winx_q;

  // Registered response outputs; they keep their value between responses.
  logic           rsp_valid_q;
  logic [31:0]    rsp_result_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_invalid_q;
  logic           rsp_inexact_q;

  logic           gnt_valid_s;
  logic [IDW-1:0] gnt_idx_s;
  logic [31:0]    gnt_opnd_s;

  logic signed [8:0] e_s;
  logic           dec_norm_s;
  logic [31:0]    dec_res_s;
  logic           dec_inv_s;
  logic           dec_inx_s;

  logic [31:0]    ext_s;
  logic [31:0]    mag_s;
  logic [31:0]    mask_s;
  logic [31:0]    shf_res_s;
  logic           shf_inx_s;
  logic [4:0]     lsh_s;
  logic [4:0]     rsh_s;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!gnt_valid_s && bus.req_valid[j] &&
            (j == ((int'(ptr_q) + k >= NREQ) ? int'(ptr_q) + k - NREQ : int'(ptr_q) + k))) begin
          gnt_valid_s = 1'b1;
          gnt_idx_s   = IDW'(j);
        end else begin
          gnt_valid_s = gnt_valid_s;
        end
      end
    end
  end

  // Operand mux, one-hot accept (IDLE only) and next pointer.
  always_comb begin
    gnt_opnd_s    = 32'd0;
    bus.req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_idx_s == IDW'(j)) begin
        gnt_opnd_s       = bus.req_a[32*j +: 32];
        bus.req_ready[j] = gnt_valid_s && (state_q == S_IDLE) && !rst;
      end else begin
        bus.req_ready[j] = 1'b0;
      end
    end
    if (gnt_idx_s == IDW'(NREQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx_s + IDW'(1);
    end
  end

  assign e_s = $signed({1'b0, opnd_q[30:23]}) - 9'sd127;

  // Operand classification: specials and saturation resolve here.
  always_comb begin
    dec_norm_s = 1'b0;
    dec_res_s  = 32'd0;
    dec_inv_s  = 1'b0;
    dec_inx_s  = 1'b0;
    if (opnd_q[30:23] == 8'hFF) begin
      dec_inv_s = 1'b1;
      if (opnd_q[22:0] != 23'd0) begin
        dec_res_s = 32'h8000_0000;
      end else if (opnd_q[31]) begin
        dec_res_s = 32'h8000_0000;
      end else begin
        dec_res_s = 32'h7FFF_FFFF;
      end
    end else if (e_s >= 9'sd31) begin
      if (opnd_q[31]) begin
        // Exactly -2^31 is representable; anything larger in magnitude is not.
        dec_res_s = 32'h8000_0000;
        dec_inv_s = (opnd_q != 32'hCF00_0000);
      end else begin
        dec_res_s = 32'h7FFF_FFFF;
        dec_inv_s = 1'b1;
      end
    end else if (e_s < 9'sd0) begin
      dec_inx_s = |opnd_q[30:0];
    end else begin
      dec_norm_s = 1'b1;
    end
  end

  // Normal-path shift, truncation flag and sign application.
  always_comb begin
    ext_s  = {8'd0, sig_q};
    lsh_s  = 5'd0;
    rsh_s  = 5'd0;
    mask_s = 32'd0;
    if (sh_q >= 5'd23) begin
      lsh_s     = sh_q - 5'd23;
      mag_s     = ext_s << lsh_s;
      shf_inx_s = 1'b0;
    end else begin
      rsh_s     = 5'd23 - sh_q;
      mag_s     = ext_s >> rsh_s;
      mask_s    = (32'd1 << rsh_s) - 32'd1;
      shf_inx_s = |(ext_s & mask_s);
    end
    if (sign_q) begin
      shf_res_s = 32'd0 - mag_s;
    end else begin
      shf_res_s = mag_s;
    end
  end

  // Sequencer FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      opnd_q        <= 32'd0;
      id_q          <= '0;
      norm_q        <= 1'b0;
      sign_q        <= 1'b0;
      sig_q         <= 24'd0;
      sh_q          <= 5'd0;
      wres_q        <= 32'd0;
      winv_q        <= 1'b0;
      winx_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 32'd0;
      rsp_id_q      <= '0;
      rsp_invalid_q <= 1'b0;
      rsp_inexact_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_valid_s) begin
            opnd_q  <= gnt_opnd_s;
            id_q    <= gnt_idx_s;
            ptr_q   <= ptr_d;
            state_q <= S_DECODE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DECODE: begin
          norm_q  <= dec_norm_s;
          sign_q  <= opnd_q[31];
          sig_q   <= {1'b1, opnd_q[22:0]};
          sh_q    <= e_s[4:0];
          wres_q  <= dec_res_s;
          winv_q  <= dec_inv_s;
          winx_q  <= dec_inx_s;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (norm_q) begin
            rsp_result_q  <= shf_res_s;
            rsp_invalid_q <= 1'b0;
            rsp_inexact_q <= shf_inx_s;
          end else begin
            rsp_result_q  <= wres_q;
            rsp_invalid_q <= winv_q;
            rsp_inexact_q <= winx_q;
          end
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_RESP;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_invalid = rsp_invalid_q;
  assign bus.rsp_inexact = rsp_inexact_q;

endmodule

// File: doc/fpu_cvt_sched.md
Name: fpu_cvt_sched

Overview:
Scheduler and sequencer for the shared float-to-int32 conversion datapath in the FPU. It arbitrates NREQ requesters round-robin onto one converter and sequences each conversion through decode, shift/negate and response states. It returns the signed 32-bit integer result (truncated toward zero) with exception flags over a valid/ready response channel. Only one conversion is in flight at a time.

Parameters:
NREQ, 2, number of requesters; legal values 2..4.
IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  NREQ  per-requester request valid.
req_ready  output  NREQ  one-hot grant/accept, combinational.
req_a  input  32*NREQ  IEEE-754 single operand for requester i, at bits [32*i+31:32*i].
rsp_valid  output  1  result valid.
rsp_ready  input  1  consumer accepts result.
rsp_result  output  32  signed int32 result.
rsp_id  output  IDW  index of the requester that owns the result.
rsp_invalid  output  1  NaN, infinity or out-of-range operand.
rsp_inexact  output  1  nonzero fraction bits were discarded.

Behaviour:
- Reset: state IDLE; rsp_valid=0, rsp_result=0, rsp_id=0, both flags=0, req_ready=0, round-robin pointer set so requester 0 has highest priority.
- Reset is sampled every cycle. Reset mid-operation aborts the conversion: no response, and the captured operand is dropped.
- FSM states are IDLE, DECODE, SHIFT and RESP.
- IDLE: if any req_valid is set, grant the first valid requester at or after the pointer (wrapping modulo NREQ).
  - Drive req_ready one-hot for the granted requester in that cycle only.
  - Capture its operand and index, set the pointer to grant+1 mod NREQ, then go to DECODE.
  - req_ready is 0 in every state other than IDLE.
- DECODE (1 cycle): compute e = A[30:23] - 127 as a 9-bit signed value and classify the operand:
  - NaN (exp=255, frac!=0): result 0x80000000, invalid=1.
  - Infinity (exp=255, frac=0): 0x7FFFFFFF if positive, 0x80000000 if negative; invalid=1.
  - e >= 31: positive -> 0x7FFFFFFF, invalid=1. Negative -> 0x80000000; invalid=0 only when A==0xCF000000 (exactly -2^31), otherwise invalid=1.
  - e < 0, including zeros and denormals: result 0; inexact = (A[30:0]!=0).
  - Otherwise: load significand {1,A[22:0]} into the shift path.
- SHIFT (1 cycle), normal path only:
  - If e >= 23, magnitude = significand << (e-23).
  - Else magnitude = significand >> (23-e), and inexact = OR of the discarded bits.
  - If sign=1, result = two's-complement negation of the magnitude.
  - Special classes pass their DECODE values through unchanged.
- RESP: drive rsp_valid=1 with rsp_result, rsp_id and the flags, all held stable until rsp_ready=1.
  - On the handshake cycle, go to IDLE. rsp_valid drops in the next cycle, and the next grant can occur in that same cycle.
- Latency: grant in cycle C; rsp_valid first asserts at C+3. Best-case throughput is one result per 4 cycles.
- -0.0 gives result 0 with no flags.
- Requests not granted remain pending; requesters must hold req_valid and req_a until granted.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...
- rsp_ready held 0 stalls the block indefinitely in RESP, with outputs unchanged and no new grants.
- rsp_result, rsp_id and the flags hold their last values when rsp_valid=0.

Test Plan:
- Basic conversion on requester 0: 0x3F800000 (1.0) -> rsp_result=1, no flags, rsp_valid at grant+3. 0x4B000001 (8388609.0) -> 8388609, exact.
- Rounding and sign: -2.5 (0xC0200000) -> 0xFFFFFFFE, inexact=1. 0.75 (0x3F400000) -> 0, inexact=1. -0.0 (0x80000000) -> 0, no flags.
- Saturation and specials:
  - 2^31 (0x4F000000) -> 0x7FFFFFFF, invalid=1.
  - -2^31 (0xCF000000) -> 0x80000000, invalid=0.
  - 0xCF000001 -> 0x80000000, invalid=1.
  - +Inf (0x7F800000) -> 0x7FFFFFFF, invalid=1.
  - NaN (0x7FC00000) -> 0x80000000, invalid=1.
- Arbitration: NREQ=2 with both requesters valid continuously for 4 conversions -> grants/rsp_id sequence 0,1,0,1. req_ready is never high for both at once, and never high outside IDLE.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and the outputs are stable and no req_ready pulses occur; release -> exactly one handshake, then the next grant.
- Reset mid-operation: assert rst in SHIFT -> next cycle state is IDLE, rsp_valid=0 and no response is issued. After reset, with both requesters valid, requester 0 is granted first.
